// File: rtl/ola_pkg.sv
// Shared definitions for the overlap-add synthesis datapath: frame geometry,
// FSM state encoding and the saturating clamp reused by datapath adders.
package ola_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAME_LEN  = 128;
  localparam int HOP        = FRAME_LEN / 2;
  localparam int IDX_W      = $clog2(FRAME_LEN);
  localparam int HOP_AW     = $clog2(HOP);

  typedef enum logic [1:0] {
    S_HEAD  = 2'd0,
    S_TAIL  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Clamp a (W+1)-bit two's-complement sum to W bits; the top two bits
  // disagree exactly when the sum left the W-bit range.
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH:0] s);
    logic [DATA_WIDTH-1:0] r;
    if (s[DATA_WIDTH] == s[DATA_WIDTH-1]) r = s[DATA_WIDTH-1:0];
    else if (!s[DATA_WIDTH])              r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else                                  r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    return r;
  endfunction

endpackage

// File: rtl/ola_synth_if.sv
// Sample-in / sample-out handshake bundle of the overlap-add stage.
interface ola_synth_if;
  import ola_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  frame_done;
  logic                  busy;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, frame_done, busy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, frame_done, busy
  );
endinterface

// File: rtl/ola_tail_ram.sv
// HOP-deep store for the second half of the previous frame: one synchronous
// write port, one asynchronous read port.
module ola_tail_ram
  import ola_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [HOP_AW-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [HOP_AW-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [HOP];

  // NOTE: storage deliberately has no reset; tail_valid in the parent masks
  // stale contents, so clearing 64 words would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ola_synth.sv
// Overlap-add synthesis: sums each frame's head with the stored tail of the
// previous frame, emits HOP saturated samples per frame, and can drain the tail.
module ola_synth
  import ola_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  ola_synth_if.slave bus
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HOP_AW-1:0]     f_q, f_d;
  logic                  tail_valid_q, tail_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  frame_done_q, frame_done_d;

  logic                  rdy, accept, flush_go, out_free, wr_en;
  logic [HOP_AW-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data, addend;
  logic [DATA_WIDTH:0]   sum;

  ola_tail_ram u_tail (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (idx_q[HOP_AW-1:0]),
    .wdata_i (bus.in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Flush wins over a simultaneous input at the frame boundary.
  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    flush_go = (state_q == S_HEAD) && (idx_q == '0) && bus.flush && tail_valid_q;
    unique case (state_q)
      S_HEAD:  rdy = out_free && !flush_go;
      S_TAIL:  rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && rdy;
  assign addend = tail_valid_q ? rd_data : '0;
  assign sum    = {bus.in_data[DATA_WIDTH-1], bus.in_data} + {addend[DATA_WIDTH-1], addend};

  // NOTE: every signal driven here is defaulted first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    f_d          = f_q;
    tail_valid_d = tail_valid_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    rd_addr      = idx_q[HOP_AW-1:0];

    unique case (state_q)
      S_HEAD: begin
        if (flush_go) begin
          state_d = S_FLUSH;
          f_d     = '0;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_add(sum);
          idx_d       = idx_q + 1'b1;
          if (idx_q == IDX_W'(HOP - 1)) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (accept) begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d      = S_HEAD;
            tail_valid_d = 1'b1;
            frame_done_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        rd_addr = f_q;
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          f_d         = f_q + 1'b1;
          if (f_q == HOP_AW'(HOP - 1)) begin
            tail_valid_d = 1'b0;
            state_d      = S_HEAD;
          end
        end
      end
      default: state_d = S_HEAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HEAD;
      idx_q        <= '0;
      f_q          <= '0;
      tail_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      f_q          <= f_d;
      tail_valid_q <= tail_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = rdy && rst_n;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (idx_q != '0) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_ola_synth.sv
// Directed bench for ola_synth: frame sums, saturation, backpressure, flush
// and mid-frame reset, with hand-computed expected outputs.
module tb_ola_synth;
  import ola_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ola_synth_if bus ();

  ola_synth dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_done   = 0;
  logic [31:0] outq[$];

  // A transfer seen at the falling edge completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
      if (bus.frame_done) n_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int head_base, input int head_step, input int tail_val);
    for (int i = 0; i < HOP; i++) send(32'(head_base + head_step * i));
    for (int i = 0; i < HOP; i++) send(32'(tail_val));
  endtask

  task automatic expect_outs(input string tag, input int base, input int step);
    int t = 0;
    while (outq.size() < HOP && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_count"}, 32'(outq.size()), 32'(HOP));
    for (int i = 0; i < HOP; i++)
      check($sformatf("%s_out%0d", tag, i),
            (i < outq.size()) ? outq[i] : 32'hxxxx_xxxx, 32'(base + step * i));
    outq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    #12;
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_data",   bus.out_data,        32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Frame A has no prior tail, frame B sees A's tail of 1000.
    send_frame(1000, 0, 1000);
    expect_outs("A", 1000, 0);
    send_frame(500, 0, 500);
    expect_outs("B", 1500, 0);
    check("done_AB", 32'(n_done), 32'd2);

    // Saturation at both ends.
    send_frame(-500, 0, 32'h7FFF_FFF0);
    expect_outs("C", 0, 0);
    send_frame(32'h20, 0, 32'h8000_0010);
    expect_outs("D_satpos", 32'h7FFF_FFFF, 0);
    send_frame(-32'h20, 0, 1000);
    expect_outs("E_satneg", 32'h8000_0000, 0);

    // Backpressure after head idx 10: output and input both hold.
    for (int i = 0; i <= 10; i++) send(32'(i));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd11;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_data",  bus.out_data,       32'd1010);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 11; i < HOP; i++) send(32'(i));
    for (int i = 0; i < HOP; i++) send(32'd1000);
    expect_outs("F_stall", 1000, 1);

    // Flush together with a pending input: flush wins and drains the tail.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd77;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd1);
    expect_outs("FLUSH", 1000, 0);
    check("post_flush_busy", 32'(bus.busy), 32'd0);
    send_frame(0, 3, 9);
    expect_outs("G_zero_tail", 0, 3);

    // Reset in the middle of a head phase.
    for (int i = 0; i < 40; i++) send(32'd1);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid",  32'(bus.out_valid),  32'd0);
    check("midrst_out_data",   bus.out_data,        32'd0);
    check("midrst_frame_done", 32'(bus.frame_done), 32'd0);
    check("midrst_busy",       32'(bus.busy),       32'd0);
    check("midrst_in_ready",   32'(bus.in_ready),   32'd0);
    outq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(7, 0, 7);
    expect_outs("I_after_rst", 7, 0);
    check("done_total", 32'(n_done), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ola_synth.md
# ola_synth

Overlap-add synthesis stage, the reconstruction-side counterpart of the Hanning windowing stage. It accepts 128-sample windowed frames (post-IFFT, 50% overlap, hop 64) one sample per handshake. Each input frame's first half is summed with the stored second half of the previous frame, and the block emits 64 saturated output samples per frame. It sits at the output of the noise-cancelling datapath, just ahead of the audio sink.

## Interface
- DATA_WIDTH, 32, signed sample width (two's complement)
- FRAME_LEN, 128, samples per input frame
- HOP, 64, samples emitted per frame, equal to FRAME_LEN/2 and the tail buffer depth
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts input this cycle
- in_data  in  DATA_WIDTH  signed windowed sample
- flush  in  1  request to drain the stored tail; sampled only in S_HEAD with idx==0
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_WIDTH  signed reconstructed sample
- frame_done  out  1  one-cycle pulse when sample 127 is accepted
- busy  out  1  high while idx!=0 or state==S_FLUSH

## Operation
- idx is a 7-bit sample counter that advances on each accepted input (in_valid&&in_ready) and wraps from 127 to 0.
- tail_valid is a flag. Reset clears it. It is set when sample 127 is accepted and cleared when a flush completes.
- State machine:
  - S_HEAD (idx 0..63): sum = in_data + (tail_valid ? tail[idx] : 0). The sum is saturated and loaded into the output register.
  - S_TAIL (idx 64..127): tail[idx-64] <= in_data. No output is produced.
  - S_FLUSH: emits tail[f] for f = 0..63 as outputs, with no input accepted. At f==63 it clears tail_valid and returns to S_HEAD.
- Transitions:
  - S_HEAD -> S_TAIL on acceptance at idx 63.
  - S_TAIL -> S_HEAD on acceptance at idx 127.
  - S_HEAD -> S_FLUSH when idx==0, flush==1 and tail_valid==1.
  - flush with tail_valid==0 is ignored.
- Simultaneous in_valid and flush at idx 0: flush wins and input is stalled (in_ready=0).
- Arithmetic:
  - The sum is computed at DATA_WIDTH+1 bits.
  - If the result is above 2^(W-1)-1, out_data = 0x7FFF_FFFF.
  - If the result is below -2^(W-1), out_data = 0x8000_0000.
  - No rounding is applied.
- in_ready:
  - S_TAIL: 1.
  - S_HEAD: !out_valid || out_ready.
  - S_FLUSH: 0.
- Tail storage needs no reset. tail_valid gates its use.

## Timing
- Reset values: in_ready=0 during reset and 1 after. out_valid=0, out_data=0, frame_done=0, busy=0, state=S_HEAD, idx=0, tail_valid=0.
- Latency: accepted S_HEAD sample at edge N gives out_valid=1 with out_data after edge N.
- Throughput: 1 sample/cycle when out_ready is held high.
- Output holding: out_valid/out_data are held stable until out_valid&&out_ready. out_valid is never dropped without a transfer.
- frame_done is asserted in the cycle after sample 127 is accepted, for one cycle only.
- S_FLUSH emits 64 outputs back-to-back when out_ready=1.
- Reset mid-frame or mid-flush: everything returns to reset values immediately. The pending output is discarded, and the next frame is treated as having a zero tail.

## Structure
- Shared package ola_pkg holds:
  - FRAME_LEN, HOP, DATA_WIDTH
  - state enum {S_HEAD, S_TAIL, S_FLUSH}
  - sat_add function (W+1 -> W clamp), reused by other datapath adders
- Sub-module ola_tail_ram is a HOP x DATA_WIDTH register array with one write port and one asynchronous read port, with no reset.
- Top level contains the FSM, idx/flush counters, saturating adder and output register.

## Test plan
- Reset, then frame A (all +1000), then frame B (all +500):
  - frame A outputs are 64 x 1000 (tail treated as zero).
  - frame B outputs are 64 x 1500.
  - frame_done pulses twice.
- Tail 0x7FFF_FFF0 plus head 0x20 gives 0x7FFF_FFFF.
- Tail 0x8000_0010 plus head -0x20 gives 0x8000_0000.
- out_ready held low for 5 cycles at head idx 10:
  - out_data holds the idx-10 sum and in_ready=0.
  - After release, all 64 outputs arrive in order with none lost or duplicated.
- After frame A, assert flush at idx 0 together with in_valid:
  - in_ready=0.
  - 64 outputs of +1000 are emitted.
  - The next frame's outputs equal its inputs.
- Assert rst_n=0 at head idx 40, with out_valid=1:
  - All outputs return to reset values immediately.
  - The next frame (all +7) outputs 64 x 7.
